// File: rtl/npu_pkg.sv
// npu_pkg: constants and state encoding shared by the
// per-core NPU transfer engines.
package npu_pkg;

    localparam int WORD_BYTES = 4;
    localparam int NPC_LW     = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_FIN
    } npc_state_t;

endpackage

// File: rtl/npc_dma_if.sv
// npc_dma_if: one npcN_* port between a core transfer engine
// and the NPU master arbiter.
interface npc_dma_if import npu_pkg::*; ();

    logic              req;
    logic              gnt;
    logic              rwn;
    logic [31:0]       adr;
    logic [NPC_LW-1:0] len;
    logic [31:0]       wdt;
    logic [31:0]       rdt;
    logic              ack;

    modport master (
        output req, rwn, adr, len, wdt,
        input  gnt, rdt, ack
    );

    modport slave (
        input  req, rwn, adr, len, wdt,
        output gnt, rdt, ack
    );

endinterface

// File: rtl/npc_dma_fifo.sv
// npc_dma_fifo: small synchronous FIFO with a combinational head.
// A pop on empty is dropped; a push on full only lands with a pop.
module npc_dma_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp];

    // Pointer and occupancy tracking; clr empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wp] <= din;
    end

endmodule

// File: rtl/npc_dma.sv
// npc_dma: per-core block transfer engine between an NP core's
// local word memory and one port of the NPU master arbiter.
module npc_dma
    import npu_pkg::*;
#(
    parameter int LM_AW    = 12,
    parameter int PF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rwn,
    input  logic [31:0]       cmd_adr,
    input  logic [NPC_LW-1:0] cmd_len,
    input  logic [LM_AW-1:0]  cmd_lad,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              lm_en,
    output logic              lm_we,
    output logic [LM_AW-1:0]  lm_adr,
    output logic [31:0]       lm_wdt,
    input  logic [31:0]       lm_rdt,
    npc_dma_if.master         npc
);
    localparam int          CW    = $clog2(PF_DEPTH) + 1;
    localparam logic [31:0] ALIGN = 32'(WORD_BYTES - 1);

    npc_state_t        st;
    npc_state_t        st_nxt;
    logic              rwn_q;
    logic [31:0]       adr_q;
    logic [NPC_LW-1:0] len_q;
    logic [NPC_LW-1:0] bcnt;
    logic [NPC_LW-1:0] rd_ptr;
    logic [LM_AW-1:0]  lad_q;
    logic [LM_AW-1:0]  wadr_q;
    logic              lwe_q;
    logic              zdone_q;
    logic              inflight;
    logic              accept;
    logic              beat;
    logic              pop;
    logic              room;
    logic              issue;
    logic [CW-1:0]     pf_cnt;
    logic              pf_empty;
    logic              pf_full;
    logic [31:0]       pf_head;

    assign accept = (st == S_IDLE) && cmd_valid
                    && (cmd_len != '0);
    assign beat   = (st == S_XFER) && npc.ack;
    assign pop    = beat && !rwn_q && !pf_empty;
    // Words queued plus the one read in flight must fit.
    assign room   = !pf_full
                    && (int'(pf_cnt) + int'(inflight) < PF_DEPTH);
    assign issue  = !rwn_q
                    && (st == S_REQ || st == S_XFER)
                    && (rd_ptr < len_q) && (room || pop);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= st_nxt;
    end

    // Next state: one grant opens the burst, the last beat closes it.
    always_comb begin
        st_nxt = st;
        unique case (st)
            S_IDLE:  if (accept) st_nxt = S_REQ;
            S_REQ:   if (npc.gnt) st_nxt = S_XFER;
            S_XFER:  if (beat && (bcnt + NPC_LW'(1)) == len_q)
                         st_nxt = S_FIN;
            S_FIN:   st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    // Command latch, beat/prefetch counters, local write-back, error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rwn_q    <= 1'b0;
            adr_q    <= '0;
            len_q    <= '0;
            lad_q    <= '0;
            bcnt     <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            zdone_q  <= 1'b0;
            lwe_q    <= 1'b0;
            wadr_q   <= '0;
            lm_wdt   <= '0;
            err      <= 1'b0;
        end else begin
            lwe_q    <= 1'b0;
            inflight <= issue;
            zdone_q  <= (st == S_IDLE) && cmd_valid
                        && (cmd_len == '0);
            if (accept) begin
                rwn_q  <= cmd_rwn;
                adr_q  <= cmd_adr & ~ALIGN;
                len_q  <= cmd_len;
                lad_q  <= cmd_lad;
                bcnt   <= '0;
                rd_ptr <= '0;
            end
            if (beat)  bcnt   <= bcnt + NPC_LW'(1);
            if (issue) rd_ptr <= rd_ptr + NPC_LW'(1);
            if (beat && !rwn_q && pf_empty) err <= 1'b1;
            if (beat && rwn_q) begin
                lwe_q  <= 1'b1;
                wadr_q <= lad_q + bcnt[LM_AW-1:0];
                lm_wdt <= npc.rdt;
            end
        end
    end

    npc_dma_fifo #(
        .DEPTH (PF_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (st == S_IDLE),
        .push  (inflight),
        .pop   (pop),
        .din   (lm_rdt),
        .head  (pf_head),
        .count (pf_cnt),
        .empty (pf_empty),
        .full  (pf_full)
    );

    assign cmd_ready = (st == S_IDLE);
    assign busy      = (st != S_IDLE);
    assign done      = zdone_q || (st == S_FIN);
    assign lm_en     = lwe_q || issue;
    assign lm_we     = lwe_q;
    assign lm_adr    = lwe_q ? wadr_q
                     : issue ? lad_q + rd_ptr[LM_AW-1:0]
                     : '0;
    assign npc.req   = (st == S_REQ);
    assign npc.rwn   = rwn_q;
    assign npc.adr   = adr_q;
    assign npc.len   = len_q;
    assign npc.wdt   = pf_empty ? '0 : pf_head;

endmodule
